// File: rtl/vga_frame_monitor.sv
// VGA receive-side frame monitor: rebuilds pixel coordinates and checks 640x480@60 timing.
// Define VGA_MON_CRC_EN to add a per-frame CRC-16-CCITT over visible pixels.
module vga_frame_monitor #(
  parameter int H_VISIBLE   = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_FRONT     = 16,
  parameter int V_VISIBLE   = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_FRONT     = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [2:0]  vgaRed,
  input  logic [2:0]  vgaGreen,
  input  logic [1:0]  vgaBlue,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [7:0]  px_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] frame_crc
);

  localparam int HT = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int VT = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  localparam logic [10:0] HLAST = 11'(HT - 1);
  localparam logic [10:0] HMAX  = 11'(2 * HT);
  localparam logic [10:0] HS0   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HEND  = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] VLAST = 11'(VT - 1);
  localparam logic [10:0] VMAX  = 11'(2 * VT);
  localparam logic [10:0] VS0   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VEND  = 11'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [7:0]  LOCKN = 8'(LOCK_FRAMES);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]  state, stNext;
  logic [7:0]  goodCnt, goodNext;
  logic [10:0] hCnt, vCnt, hNext, vNext;
  logic        hsQ, vsQ, vPend;
  logic        lineValid, lineDirty;
  logic        hFall, vFall, vPendEff, boundary;
  logic        hTmo, vTmo, lineChk, frameChk;
  logic        inTrack, clean, doneNow, win, vis;
  logic [7:0]  rgbIn;

  assign rgbIn = {vgaRed, vgaGreen, vgaBlue};

  always_comb begin
    hFall    = hsQ & ~Hsync;
    vFall    = vsQ & ~Vsync;
    vPendEff = vPend | vFall;
    boundary = hFall & vPendEff;
    inTrack  = (state != S_SEARCH);
    hTmo     = !hFall && (hCnt == HMAX - 11'd1);
    vTmo     = hFall && !vPendEff && (vCnt == VMAX - 11'd1);
    lineChk  = inTrack && lineValid && hFall && (hCnt != HLAST);
    frameChk = inTrack && boundary && (vCnt != VLAST);
    clean    = !lineDirty && !lineChk && !frameChk;

    if (hFall)             hNext = '0;
    else if (hCnt == HMAX) hNext = hCnt;
    else                   hNext = hCnt + 11'd1;

    if (boundary)             vNext = '0;
    else if (!hFall)          vNext = vCnt;
    else if (vCnt == VMAX)    vNext = vCnt;
    else                      vNext = vCnt + 11'd1;
  end

  always_comb begin
    stNext   = state;
    goodNext = goodCnt;
    doneNow  = 1'b0;
    if (hTmo || vTmo) begin
      stNext   = S_SEARCH;
      goodNext = '0;
    end else begin
      unique case (1'b1)
        (state == S_SEARCH): begin
          if (boundary) begin
            stNext   = S_TRACK;
            goodNext = '0;
          end
        end
        (state == S_TRACK): begin
          if (boundary) begin
            if (clean) begin
              goodNext = goodCnt + 8'd1;
              if (goodCnt + 8'd1 == LOCKN) begin
                stNext  = S_LOCKED;
                doneNow = 1'b1;
              end
            end else begin
              goodNext = '0;
            end
          end else if (lineChk) begin
            goodNext = '0;
          end
        end
        default: begin
          if (lineChk || frameChk || (boundary && lineDirty)) begin
            stNext   = S_TRACK;
            goodNext = '0;
          end else if (boundary) begin
            doneNow = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    win = (hNext >= HS0) && (hNext < HEND) &&
          (vNext >= VS0) && (vNext < VEND);
    vis = win && (stNext != S_SEARCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SEARCH;
      goodCnt    <= '0;
      hCnt       <= '0;
      vCnt       <= '0;
      hsQ        <= 1'b1;
      vsQ        <= 1'b1;
      vPend      <= 1'b0;
      lineValid  <= 1'b0;
      lineDirty  <= 1'b0;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_rgb     <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      px_valid   <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      if (pix_en) begin
        hsQ     <= Hsync;
        vsQ     <= Vsync;
        hCnt    <= hNext;
        vCnt    <= vNext;
        vPend   <= vPendEff & ~hFall;
        state   <= stNext;
        goodCnt <= goodNext;
        locked  <= (stNext == S_LOCKED);
        // the line that opens tracking carries no trusted start point
        if (state == S_SEARCH && stNext == S_TRACK) lineValid <= 1'b0;
        else if (hFall)                             lineValid <= 1'b1;
        if (boundary)     lineDirty <= 1'b0;
        else if (lineChk) lineDirty <= 1'b1;
        line_err   <= lineChk | hTmo;
        frame_err  <= frameChk | vTmo;
        frame_done <= doneNow;
        if (doneNow) frame_cnt <= frame_cnt + 16'd1;
        if (vis) begin
          px_valid <= 1'b1;
          px_x     <= 10'(hNext - HS0);
          px_y     <= 10'(vNext - VS0);
          px_rgb   <= rgbIn;
        end
      end
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crcByte(input logic [15:0] c,
                                          input logic [7:0]  d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else if (pix_en) begin
      if (boundary) begin
        frame_crc <= crc;
        crc       <= 16'hFFFF;
      end else if (win) begin
        crc <= crcByte(crc, rgbIn);
      end
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Randomized bench for vga_frame_monitor on a shrunken raster.
// Honours VGA_MON_CRC_EN when checking frame_crc.
module tb_vga_frame_monitor;

  localparam int HV = 8, HSY = 2, HBK = 3, HFR = 2;
  localparam int VV = 4, VSY = 1, VBK = 2, VFR = 2;
  localparam int LOCKF = 2;
  localparam int HT  = HV + HSY + HBK + HFR;
  localparam int VT  = VV + VSY + VBK + VFR;
  localparam int HS0 = HSY + HBK;
  localparam int VS0 = VSY + VBK;
  localparam int MS = 0, MT = 1, ML = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic Hsync = 1'b1;
  logic Vsync = 1'b1;
  logic [2:0] vgaRed = '0;
  logic [2:0] vgaGreen = '0;
  logic [1:0] vgaBlue = '0;
  logic px_valid, locked, frame_done, line_err, frame_err;
  logic [9:0] px_x, px_y;
  logic [7:0] px_rgb;
  logic [15:0] frame_cnt, frame_crc;

  vga_frame_monitor #(
    .H_VISIBLE(HV), .H_SYNC(HSY), .H_BACK(HBK), .H_FRONT(HFR),
    .V_VISIBLE(VV), .V_SYNC(VSY), .V_BACK(VBK), .V_FRONT(VFR),
    .LOCK_FRAMES(LOCKF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .Hsync(Hsync), .Vsync(Vsync),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .locked(locked), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int  mode, good, hpos, vpos, fcnt;
  bit  pHs, pVs, pendV, checked, dirty;
  logic [15:0] crcM, expCrc;
  bit  eValid, eLerr, eFerr, eDone;
  int  eX, eY;
  logic [7:0] eRgb;

  function automatic logic [15:0] crcStep(input logic [15:0] c,
                                          input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic modelReset();
    mode = MS; good = 0; hpos = 0; vpos = 0; fcnt = 0;
    pHs = 1; pVs = 1; pendV = 0; checked = 0; dirty = 0;
    crcM = 16'hFFFF; expCrc = 16'h0000;
  endtask

  task automatic modelStep(input bit hs, input bit vs, input logic [7:0] rgb);
    bit hf, vf, bnd, tmo, cleanF, inWin;
    hf = pHs && !hs;
    vf = pVs && !vs;
    pHs = hs;
    pVs = vs;
    if (vf) pendV = 1;
    eLerr = 0; eFerr = 0; eDone = 0; bnd = 0; tmo = 0;
    if (hf) begin
      if (mode != MS && checked && hpos != HT - 1) eLerr = 1;
      checked = 1;
      hpos = 0;
      if (pendV) begin
        bnd = 1;
        pendV = 0;
        if (mode != MS && vpos != VT - 1) eFerr = 1;
        vpos = 0;
      end else begin
        vpos++;
        if (vpos == 2 * VT) begin eFerr = 1; tmo = 1; end
      end
    end else begin
      hpos++;
      if (hpos == 2 * HT) begin eLerr = 1; tmo = 1; end
    end
    if (tmo) begin
      mode = MS; good = 0;
    end else if (mode == MS) begin
      if (bnd) begin mode = MT; good = 0; dirty = 0; checked = 0; end
    end else if (bnd) begin
      cleanF = !dirty && !eLerr && !eFerr;
      dirty = 0;
      if (!cleanF) begin
        mode = MT; good = 0;
      end else if (mode == ML) begin
        eDone = 1; fcnt++;
      end else begin
        good++;
        if (good == LOCKF) begin mode = ML; eDone = 1; fcnt++; end
      end
    end else if (eLerr) begin
      dirty = 1; good = 0;
      if (mode == ML) mode = MT;
    end
    inWin = hpos >= HS0 && hpos < HS0 + HV && vpos >= VS0 && vpos < VS0 + VV;
    eValid = inWin && mode != MS;
    eX = hpos - HS0;
    eY = vpos - VS0;
    eRgb = rgb;
    if (bnd) begin
      expCrc = crcM;
      crcM = 16'hFFFF;
    end else if (inWin) begin
      crcM = crcStep(crcM, rgb);
    end
  endtask

  task automatic sample(input bit hs, input bit vs, input logic [7:0] rgb);
    @(negedge clk);
    chk("idle_pulses", {px_valid, line_err, frame_err, frame_done}, 0);
    Hsync = hs;
    Vsync = vs;
    {vgaRed, vgaGreen, vgaBlue} = rgb;
    pix_en = 1'b1;
    modelStep(hs, vs, rgb);
    @(negedge clk);
    pix_en = 1'b0;
    chk("px_valid", px_valid, eValid);
    chk("line_err", line_err, eLerr);
    chk("frame_err", frame_err, eFerr);
    chk("frame_done", frame_done, eDone);
    chk("locked", locked, mode == ML);
    chk("frame_cnt", frame_cnt, fcnt & 16'hFFFF);
`ifdef VGA_MON_CRC_EN
    chk("frame_crc", frame_crc, expCrc);
`else
    chk("frame_crc", frame_crc, 0);
`endif
    if (eValid) begin
      chk("px_x", px_x, eX);
      chk("px_y", px_y, eY);
      chk("px_rgb", px_rgb, eRgb);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic frame(input int lines, input int badLine,
                       input int badLen, input bit zero);
    int len;
    for (int l = 0; l < lines; l++) begin
      len = (l == badLine) ? badLen : HT;
      for (int p = 0; p < len; p++)
        sample(p >= HSY, l >= VSY, zero ? 8'h00 : 8'($urandom));
    end
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    chk("rst_outs", {px_valid, locked, frame_done, line_err, frame_err}, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_crc", frame_crc, 0);
    chk("rst_pix", {px_x, px_y, px_rgb}, 0);
    rst_n = 1'b1;

    // ideal raster: lock at the third boundary
    repeat (4) frame(VT, -1, 0, 0);
    chk("lockA", locked, 1);
    chk("cntA", frame_cnt, 2);

    // one short line while locked
    frame(VT, 5, HT - 1, 0);
    chk("short_unlock", locked, 0);
    repeat (3) frame(VT, -1, 0, 0);
    chk("lockB", locked, 1);
    chk("cntB", frame_cnt, 4);

    // one short frame
    frame(VT - 1, -1, 0, 0);
    frame(VT, -1, 0, 0);
    chk("shortF_track", locked, 0);
    repeat (2) frame(VT, -1, 0, 0);
    chk("lockC", locked, 1);
    chk("cntC", frame_cnt, 6);

    // Hsync stuck high past the line timeout
    repeat (2 * HT + 3) sample(1'b1, 1'b1, 8'($urandom));
    chk("tmo_unlock", locked, 0);
    repeat (4) frame(VT, -1, 0, 0);
    chk("lockD", locked, 1);
    chk("cntD", frame_cnt, 8);

    // reset mid-frame while locked
    frame(VT / 2, -1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {px_valid, locked, frame_done, line_err, frame_err}, 0);
    chk("mid_rst_cnt", frame_cnt, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) frame(VT, -1, 0, 0);
    chk("lockE", locked, 1);
    chk("cntE", frame_cnt, 2);

    // black frames then jittered raster
    repeat (3) frame(VT, -1, 0, 1);
    for (int f = 0; f < 8; f++)
      frame(($urandom_range(0, 5) == 0) ? VT - 1 + $urandom_range(0, 2) : VT,
            $urandom_range(0, 3 * VT), HT - 1 + $urandom_range(0, 2), 0);
    repeat (3) frame(VT, -1, 0, 0);
    chk("lockF", locked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
